// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer; PIPE_SKID_PERF_EN adds stall/transfer counters.
// Latency: 1 cycle from in_fire to out_valid when empty or draining; sustained 1 entry/cycle with out_ready=1.
// Backpressure: in_ready is a function of registered state only and drops just when main and skid are both held.
module pipe_skid_stage #(
    parameter int                DATA_W       = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = 64'h0000000000000013,
    parameter int                CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_SKID_PERF_EN
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  xfer_count,
`endif
    output logic [DATA_W-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_in_fire;
    logic              w_out_fire;

    assign out_valid  = (r_state != EMPTY);
    assign in_ready   = (r_state != FULL);
    assign out_data   = r_main;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // A concurrent out_fire is already consumed downstream; only held entries are dropped.
            w_state_nxt = EMPTY;
            w_main_nxt  = BUBBLE_VALUE;
            w_skid_nxt  = BUBBLE_VALUE;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = FULL;
                    end else if (w_out_fire) begin
                        w_main_nxt  = BUBBLE_VALUE;
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = BUSY;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = BUBBLE_VALUE;
                    w_skid_nxt  = BUBBLE_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE_VALUE;
            r_skid  <= BUBBLE_VALUE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_xfer_count;

    // Counters survive flush so that flush storms remain visible in the statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_xfer_count   <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_out_fire) begin
                r_xfer_count <= r_xfer_count + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign xfer_count   = r_xfer_count;
`else
    // CNT_W only sizes the counters; keep it referenced when they are compiled out.
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule
